// File: rtl/keypad_pkg.sv
// Shared types for the 4x3 matrix keypad encoder: geometry, candidate
// classification, scan FSM states and the row/column to key-code mapping.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    typedef logic [3:0] key_t;

    // Outcome of one full scan of the matrix.
    typedef enum logic [1:0] {
        CAND_NONE   = 2'd0,
        CAND_SINGLE = 2'd1,
        CAND_MULTI  = 2'd2
    } cand_e;

    // Column scan sequencer states.
    typedef enum logic [1:0] {
        ST_DRIVE  = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EVAL   = 2'd2
    } scan_state_e;

    // Key code for a row/column intersection: row*3 + col.
    function automatic key_t key_code(input logic [1:0] row, input logic [1:0] col);
        return key_t'({2'b00, row} * 4'd3 + {2'b00, col});
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces the per-scan candidate: a new candidate must repeat for
// DEBOUNCE_SCANS consecutive scans before it changes key/key_valid.
// A ghosting (MULTI) scan is folded into NONE before debouncing, so the
// two never restart each other's stability count.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  eval,
    input  cand_e cand,
    input  key_t  code,
    output key_t  key,
    output logic  key_valid,
    output logic  key_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic             prev_single_q, prev_single_d;
    key_t             prev_code_q, prev_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_t             key_q, key_d;
    logic             valid_q, valid_d;
    logic             press_q, press_d;
    logic             new_single_s;
    logic             same_s;
    logic             accept_s;

    // Stability counting and debounced output update on each end-of-scan strobe.
    always_comb begin
        prev_single_d = prev_single_q;
        prev_code_d   = prev_code_q;
        cnt_d         = cnt_q;
        key_d         = key_q;
        valid_d       = valid_q;
        press_d       = 1'b0;
        accept_s      = 1'b0;
        new_single_s  = (cand == CAND_SINGLE);
        same_s        = (new_single_s == prev_single_q) &&
                        (!new_single_s || (code == prev_code_q));
        if (eval) begin
            if (same_s) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                prev_single_d = new_single_s;
                prev_code_d   = new_single_s ? code : 4'd0;
                cnt_d         = CNT_W'(1);
            end
            // Only the scan on which the count first reaches the threshold commits.
            accept_s = (cnt_d == CNT_MAX) && (!same_s || (cnt_q != CNT_MAX));
            if (accept_s) begin
                if (new_single_s) begin
                    key_d   = code;
                    valid_d = 1'b1;
                    press_d = !valid_q || (code != key_q);
                end else begin
                    valid_d = 1'b0;
                end
            end else begin
                valid_d = valid_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_single_q <= 1'b0;
            prev_code_q   <= 4'd0;
            cnt_q         <= '0;
            key_q         <= 4'd0;
            valid_q       <= 1'b0;
            press_q       <= 1'b0;
        end else begin
            prev_single_q <= prev_single_d;
            prev_code_q   <= prev_code_d;
            cnt_q         <= cnt_d;
            key_q         <= key_d;
            valid_q       <= valid_d;
            press_q       <= press_d;
        end
    end

    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_press = press_q;

endmodule

// File: rtl/keypad_encoder.sv
// 4x3 active-low keypad scanner/encoder. Drives one column at a time,
// samples the rows, classifies each full scan and hands the result to
// keypad_debounce. Optional macro KEYPAD_SYNC_EN inserts a 2-flop row
// synchroniser; otherwise rows are registered once.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_press
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] LAST_DRIVE = DIV_W'(SCAN_DIV - 2);

    scan_state_e                           state_q, state_d;
    logic [DIV_W-1:0]                      div_q, div_d;
    logic [1:0]                            col_q, col_d;
    logic [2:0]                            col_n_q, col_n_d;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]     hit_q, hit_d;
    logic [3:0]                            row_s;
    logic [3:0]                            n_hits_s;
    key_t                                  code_s;
    cand_e                                 cand_s;
    logic                                  eval_s;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] row_meta_q;
    logic [3:0] row_sync_q;

    // Two-flop synchroniser on the asynchronous keypad rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end
`else
    logic [3:0] row_sync_q;

    // Single input register on the keypad rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_sync_q <= 4'hF;
        end else begin
            row_sync_q <= row_n;
        end
    end
`endif

    assign row_s = row_sync_q;

    // Scan sequencer: hold each column, sample it, then evaluate after column 2.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        col_d   = col_q;
        hit_d   = hit_q;
        case (state_q)
            ST_DRIVE: begin
                div_d = div_q + DIV_W'(1);
                if (div_q == LAST_DRIVE) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                div_d = '0;
                case (col_q)
                    2'd0:    hit_d[0] = ~row_s;
                    2'd1:    hit_d[1] = ~row_s;
                    2'd2:    hit_d[2] = ~row_s;
                    default: hit_d    = hit_q;
                endcase
                if (col_q == 2'd2) begin
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_DRIVE;
                    col_d   = col_q + 2'd1;
                end
            end
            ST_EVAL: begin
                state_d = ST_DRIVE;
                div_d   = '0;
                col_d   = 2'd0;
            end
            default: begin
                state_d = ST_DRIVE;
                div_d   = '0;
                col_d   = 2'd0;
            end
        endcase
        case (col_d)
            2'd0:    col_n_d = 3'b110;
            2'd1:    col_n_d = 3'b101;
            2'd2:    col_n_d = 3'b011;
            default: col_n_d = 3'b110;
        endcase
    end

    // Scan sequencer registers, including the registered column drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DRIVE;
            div_q   <= '0;
            col_q   <= 2'd0;
            col_n_q <= 3'b110;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            col_q   <= col_d;
            col_n_q <= col_n_d;
            hit_q   <= hit_d;
        end
    end

    // Classify the completed scan: count intersections and keep the last code.
    always_comb begin
        n_hits_s = 4'd0;
        code_s   = 4'd0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (hit_q[c][r]) begin
                    n_hits_s = n_hits_s + 4'd1;
                    code_s   = key_code(2'(r), 2'(c));
                end else begin
                    n_hits_s = n_hits_s;
                end
            end
        end
        if (n_hits_s == 4'd0) begin
            cand_s = CAND_NONE;
        end else if (n_hits_s == 4'd1) begin
            cand_s = CAND_SINGLE;
        end else begin
            cand_s = CAND_MULTI;
        end
    end

    assign eval_s = (state_q == ST_EVAL);
    assign col_n  = col_n_q;

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .eval      (eval_s),
        .cand      (cand_s),
        .code      (code_s),
        .key       (key),
        .key_valid (key_valid),
        .key_press (key_press)
    );

endmodule
